uart_tx_core: RTL
=================

Name: uart_tx_core

Overview:
Transmit half of the UART. Accepts a byte from the register bus into a one-entry holding register and serialises it as 8N1, LSB first, on txd. Bit timing comes from the mode-register outputs osm_sel (13X/16X oversampling) and br (9600/19200 baud). It is the consumer end of the mode-register interface and the counterpart of the receiver.

Parameters:
CLK_HZ, 3993600, m_clk frequency in Hz; must equal 9600*13*32.
TX_ADDR, 8'h00, register address of the transmit holding register (THR).

Ports:
m_clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
address  input  8  register bus address
data_in  input  8  register bus write data
wr  input  1  write strobe; a THR write happens when wr=1 and address==TX_ADDR
osm_sel  input  1  0 = 13X oversampling, 1 = 16X oversampling
br  input  1  0 = 9600 baud, 1 = 19200 baud
txd  output  1  serial output; idles high
tx_busy  output  1  high while a frame is on the line
thr_empty  output  1  high when the holding register can accept a byte
tx_done  output  1  one-cycle pulse at the end of each stop bit
overrun  output  1  sticky; set when a write arrives while THR is full

Behaviour:
- Reset (asynchronous, active-high) sets: txd=1, tx_busy=0, thr_empty=1, tx_done=0, overrun=0, FSM=IDLE, all counters=0. Asserting reset mid-frame forces txd high immediately; the frame is lost.
- Tick divisor DIV = CLK_HZ/(baud*OSM), where baud is 9600 or 19200 and OSM is 13 or 16:
  - {osm_sel,br} = 00 -> 32, 10 -> 26, 01 -> 16, 11 -> 13.
  - One bit = OSM ticks: 416 clocks at 9600, 208 clocks at 19200.
- osm_sel and br are latched when a frame starts. Changes during a frame take effect at the next frame start.
- THR write, accepted on the rising edge where wr=1 and address==TX_ADDR:
  - If thr_empty=1: store data_in, thr_empty<=0.
  - If thr_empty=0: discard the data, set overrun<=1. overrun clears only on reset.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if thr_empty=0 at an edge, go to START on that edge. The THR moves to the shift register, thr_empty<=1, tx_busy<=1, txd<=0, tick and bit counters clear.
  - Latency: a write on edge k into an idle core drives txd low after edge k+1.
  - START: hold txd=0 for OSM ticks, then go to DATA with bit index 0.
  - DATA: txd = shift[idx]; each bit lasts OSM ticks; after idx 7, go to STOP.
  - STOP: txd=1 for OSM ticks. On its final clock, tx_done pulses for exactly one cycle.
    - If THR is full on that clock, go directly to START with no idle gap; tx_busy stays 1.
    - Otherwise go to IDLE and drop tx_busy.
- A THR write landing on the same edge the FSM empties the THR is accepted with no overrun. The transfer to the shift register takes priority, and the new byte is held in THR.
- A frame is exactly 10*OSM*DIV clocks, ±0 cycles.
- The tick counter runs only while tx_busy=1 and reloads at every frame start, so there is no phase carry-over between frames.

Decomposition:
- Shared include uart_defs: register addresses (TX_ADDR, MDR address 8'h04), OSM constants 13/16, the four DIV values, FSM state encodings.
- Sub-module uart_baud_tick: takes the latched osm_sel/br and an enable; produces a one-cycle sample tick every DIV clocks and a bit_end pulse every OSM ticks. The parent FSM instantiates it once.

Test Plan:
- Reset mid-frame: assert reset during bit 3 -> txd=1 in the same cycle, tx_busy=0, thr_empty=1; no tx_done afterwards.
- Single byte, {osm_sel,br}=00: write 8'hA5 -> txd low one edge after the write; line carries 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each bit exactly 416 clocks; one tx_done pulse; tx_busy=0 after 4160 clocks.
- All four modes: send 8'h55 with {osm_sel,br}=01/10/11 -> bit periods of 208/416/208 clocks (16*13, 26*16, 13*16); toggling br mid-frame leaves the current frame's timing unchanged.
- Back-to-back: write 8'h01, then 8'h80 while the first is busy -> second start bit begins on the clock after the first frame's last stop clock; tx_busy never drops; two tx_done pulses 4160 clocks apart.
- Overrun: write three bytes quickly while busy -> third write sets overrun=1; only the first two bytes appear on txd.
- Address filter: wr=1 with address=8'h04 -> thr_empty stays 1, txd stays high.

Source files
------------

// File: rtl/uart_tx_core_pkg.sv
// Shared UART constants: register map, oversampling ratios,
// tick divisors and transmit FSM encoding.
package uart_tx_core_pkg;

  localparam logic [7:0] TX_ADDR_DEF = 8'h00;
  localparam logic [7:0] MDR_ADDR    = 8'h04;

  localparam int unsigned OSM_13 = 13;
  localparam int unsigned OSM_16 = 16;

  // Keyed by {osm_sel, br}
  localparam int unsigned DIV_00 = 32;
  localparam int unsigned DIV_10 = 26;
  localparam int unsigned DIV_01 = 16;
  localparam int unsigned DIV_11 = 13;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: a tick every DIV clocks and a
// bit_end pulse on every OSM-th tick.
module uart_baud_tick
  import uart_tx_core_pkg::*;
#(
  parameter int unsigned DIV_A = DIV_00,
  parameter int unsigned DIV_B = DIV_10,
  parameter int unsigned DIV_C = DIV_01,
  parameter int unsigned DIV_D = DIV_11
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  input  logic osm_sel,
  input  logic br,
  output logic tick,
  output logic bit_end
);

  logic [4:0] div_cnt_q;
  logic [4:0] div_cnt_d;
  logic [4:0] div_last;
  logic [3:0] tck_cnt_q;
  logic [3:0] tck_cnt_d;
  logic [3:0] tck_last;

  always_comb begin
    div_last = 5'(DIV_A - 1);
    unique case ({osm_sel, br})
      2'b00: div_last = 5'(DIV_A - 1);
      2'b10: div_last = 5'(DIV_B - 1);
      2'b01: div_last = 5'(DIV_C - 1);
      2'b11: div_last = 5'(DIV_D - 1);
    endcase
  end

  assign tck_last = osm_sel ? 4'(OSM_16 - 1)
                            : 4'(OSM_13 - 1);

  assign tick    = en & (div_cnt_q == div_last);
  assign bit_end = tick & (tck_cnt_q == tck_last);

  always_comb begin
    div_cnt_d = div_cnt_q;
    tck_cnt_d = tck_cnt_q;
    if (clr) begin
      div_cnt_d = '0;
      tck_cnt_d = '0;
    end else if (en) begin
      div_cnt_d = tick ? '0 : div_cnt_q + 5'd1;
      if (tick) begin
        tck_cnt_d = bit_end ? '0 : tck_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      tck_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tck_cnt_q <= tck_cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_core.sv
// UART transmitter: one-entry holding register feeding an
// 8N1 LSB-first serialiser.
module uart_tx_core
  import uart_tx_core_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 3993600,
  parameter logic [7:0]  TX_ADDR = TX_ADDR_DEF
) (
  input  logic       m_clk,
  input  logic       reset,
  input  logic [7:0] address,
  input  logic [7:0] data_in,
  input  logic       wr,
  input  logic       osm_sel,
  input  logic       br,
  output logic       txd,
  output logic       tx_busy,
  output logic       thr_empty,
  output logic       tx_done,
  output logic       overrun
);

  localparam int unsigned D00 = CLK_HZ / (9600 * OSM_13);
  localparam int unsigned D10 = CLK_HZ / (9600 * OSM_16);
  localparam int unsigned D01 = CLK_HZ / (19200 * OSM_13);
  localparam int unsigned D11 = CLK_HZ / (19200 * OSM_16);

  tx_state_e  state_q, state_d;
  logic       txd_q, txd_d;
  logic       busy_q, busy_d;
  logic [7:0] thr_q, thr_d;
  logic       thr_empty_q, thr_empty_d;
  logic       overrun_q, overrun_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] idx_q, idx_d;
  logic       osm_q, osm_d;
  logic       br_q, br_d;

  logic load;
  logic wr_hit;
  logic tick;
  logic bit_end;
  logic step;

  uart_baud_tick #(
    .DIV_A(D00),
    .DIV_B(D10),
    .DIV_C(D01),
    .DIV_D(D11)
  ) u_tick (
    .clk    (m_clk),
    .rst    (reset),
    .en     (busy_q),
    .clr    (load),
    .osm_sel(osm_q),
    .br     (br_q),
    .tick   (tick),
    .bit_end(bit_end)
  );

  assign step   = tick & bit_end;
  assign wr_hit = wr & (address == TX_ADDR);

  always_comb begin
    state_d = state_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    osm_d   = osm_q;
    br_d    = br_q;
    load    = 1'b0;
    tx_done = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        load = ~thr_empty_q;
      end
      S_START: begin
        if (step) begin
          state_d = S_DATA;
          idx_d   = 3'd0;
          txd_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (step) begin
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
            txd_d = shift_q[3'(idx_q + 3'd1)];
          end
        end
      end
      S_STOP: begin
        if (step) begin
          tx_done = 1'b1;
          if (!thr_empty_q) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
      end
    endcase

    // Frame start: mode is frozen here for the whole frame
    if (load) begin
      state_d = S_START;
      shift_d = thr_q;
      busy_d  = 1'b1;
      txd_d   = 1'b0;
      idx_d   = 3'd0;
      osm_d   = osm_sel;
      br_d    = br;
    end
  end

  always_comb begin
    thr_d       = thr_q;
    thr_empty_d = thr_empty_q;
    overrun_d   = overrun_q;
    if (load) begin
      thr_empty_d = 1'b1;
    end
    if (wr_hit) begin
      if (thr_empty_q || load) begin
        thr_d       = data_in;
        thr_empty_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge m_clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      thr_q       <= '0;
      thr_empty_q <= 1'b1;
      overrun_q   <= 1'b0;
      shift_q     <= '0;
      idx_q       <= '0;
      osm_q       <= 1'b0;
      br_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
      thr_q       <= thr_d;
      thr_empty_q <= thr_empty_d;
      overrun_q   <= overrun_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      osm_q       <= osm_d;
      br_q        <= br_d;
    end
  end

  assign txd       = txd_q;
  assign tx_busy   = busy_q;
  assign thr_empty = thr_empty_q;
  assign overrun   = overrun_q;

endmodule
